// File: rtl/awgn_adder.sv
// Channel impairment stage: adds a buffered Gaussian noise sample to each s<8,6>
// symbol, rounds half-up and saturates back to s<8,6>. Latency 2, no back-pressure.
module awgn_adder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [7:0]       i_data,
  input  logic             i_valid,
  input  logic [15:0]      i_noise_data,
  input  logic             i_noise_valid,
  input  logic             i_noise_en,
  output logic             o_noise_ce,
  output logic [7:0]       o_data,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_underrun_cnt,
  output logic [CNT_W-1:0] o_overflow_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CE_LIMIT_L = (AW+1)'(FIFO_DEPTH - 2);

  // Handshake: i_valid and i_noise_valid are one-cycle qualifiers with no ready;
  // o_valid follows every i_valid exactly two cycles later and cannot be stalled.

  logic [15:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  logic              overflow;
  logic              underrun;
  logic [15:0]       noise_sel;
  logic signed [16:0] sym_al;
  logic signed [16:0] noise_ext;
  logic signed [16:0] sum;
  logic signed [16:0] s1_sum;
  logic              s1_valid;
  logic signed [16:0] rnd;
  logic signed [16:0] shifted;
  logic [7:0]        sat;

  always_comb begin
    full      = (count == DEPTH_L);
    empty     = (count == '0);
    pop       = i_valid & i_noise_en & ~empty;
    underrun  = i_valid & i_noise_en & empty;
    // A pop frees the head slot at the same edge, so a full FIFO can still accept.
    push      = i_noise_valid & (~full | pop);
    overflow  = i_noise_valid & full & ~pop;
    noise_sel = pop ? mem[rd_ptr] : 16'h0000;
    sym_al    = {{4{i_data[7]}}, i_data, 5'b00000};
    noise_ext = {noise_sel[15], noise_sel};
    sum       = sym_al + noise_ext;
  end

  always_ff @(posedge i_clock) begin
    if (push) begin
      mem[wr_ptr] <= i_noise_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      o_noise_ce <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Threshold of DEPTH-2 leaves room for one sample already in flight.
      o_noise_ce <= (count <= CE_LIMIT_L);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_underrun_cnt <= '0;
      o_overflow_cnt <= '0;
    end else begin
      if (underrun && (o_underrun_cnt != '1)) o_underrun_cnt <= o_underrun_cnt + 1'b1;
      if (overflow && (o_overflow_cnt != '1)) o_overflow_cnt <= o_overflow_cnt + 1'b1;
    end
  end

  always_comb begin
    rnd     = s1_sum + 17'sd16;
    shifted = rnd >>> 5;
    if (shifted > 17'sd127) begin
      sat = 8'h7F;
    end else if (shifted < -17'sd128) begin
      sat = 8'h80;
    end else begin
      sat = shifted[7:0];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      s1_sum   <= '0;
      s1_valid <= 1'b0;
      o_data   <= 8'h00;
      o_valid  <= 1'b0;
    end else begin
      s1_valid <= i_valid;
      if (i_valid) s1_sum <= sum;
      o_valid <= s1_valid;
      if (s1_valid) o_data <= sat;
    end
  end

endmodule
